// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED panel constants, SPI word layout and writer states
package oled_pkg;

    localparam int SPI_W  = 10;
    localparam int DC_BIT = 8;

    localparam logic [7:0] SET_PAGE   = 8'hB0;
    localparam logic [7:0] SET_COL_LO = 8'h00;
    localparam logic [7:0] SET_COL_HI = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_LATCH,
        ST_WAIT,
        ST_FIN
    } fw_state_t;

endpackage

// File: rtl/oled_frame_writer.sv
// rtl/oled_frame_writer.sv - streams one framebuffer frame to the OLED SPI serializer
module oled_frame_writer
    import oled_pkg::*;
#(
    parameter int COLS       = 128,
    parameter int PAGES      = 8,
    parameter int COL_OFFSET = 0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [9:0]       fb_addr,
    input  logic [7:0]       fb_rd_data,
    output logic [SPI_W-1:0] spi_data,
    output logic             spi_start,
    input  logic             spi_done
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [7:0]    OFF8      = 8'(COL_OFFSET);

    fw_state_t        state;
    logic [PW-1:0]    page;
    logic [CW-1:0]    col;
    logic [1:0]       cmd_idx;
    logic [SPI_W-1:0] held_word;
    logic [7:0]       cmd_byte;

    function automatic logic [9:0] page_base(input logic [PW-1:0] p);
        return 10'(p) * 10'(COLS);
    endfunction

    always_comb begin
        cmd_byte = SET_COL_HI | {4'h0, OFF8[7:4]};
        case (cmd_idx)
            2'd0:    cmd_byte = SET_PAGE | 8'(page);
            2'd1:    cmd_byte = SET_COL_LO | {4'h0, OFF8[3:0]};
            default: cmd_byte = SET_COL_HI | {4'h0, OFF8[7:4]};
        endcase
    end

    // Outputs decode the state register so a RAM byte goes out the cycle it arrives.
    assign busy      = (state != ST_IDLE) && (state != ST_FIN);
    assign done      = (state == ST_FIN);
    assign spi_start = (state == ST_CMD) || (state == ST_LATCH);

    always_comb begin
        spi_data = held_word;
        case (state)
            ST_CMD:   spi_data = {2'b00, cmd_byte};
            ST_LATCH: spi_data = {2'b01, fb_rd_data};
            default:  spi_data = held_word;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            page      <= '0;
            col       <= '0;
            cmd_idx   <= '0;
            held_word <= '0;
            fb_addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        page    <= '0;
                        cmd_idx <= '0;
                        state   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    held_word <= {2'b00, cmd_byte};
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (spi_done) begin
                        // The DC bit of the word in flight tells command from data.
                        if (!held_word[DC_BIT]) begin
                            if (cmd_idx != 2'd2) begin
                                cmd_idx <= cmd_idx + 2'd1;
                                state   <= ST_CMD;
                            end else begin
                                col     <= '0;
                                fb_addr <= page_base(page);
                                state   <= ST_FETCH;
                            end
                        end else if (col != COL_LAST) begin
                            col     <= col + CW'(1);
                            fb_addr <= fb_addr + 10'd1;
                            state   <= ST_FETCH;
                        end else if (page != PAGE_LAST) begin
                            page    <= page + PW'(1);
                            cmd_idx <= '0;
                            state   <= ST_CMD;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FETCH: state <= ST_LATCH;
                ST_LATCH: begin
                    held_word <= {2'b01, fb_rd_data};
                    state     <= ST_WAIT;
                end
                ST_FIN:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
